softmax_div_ctrl: RTL and testbench

Row-normalization sequencer for the softmax stage of the attention datapath. It accepts one row of ROW_LEN exponentiated scores and buffers them while summing. It then drives a single external combinational fixed-point divider (signed, D_W bits, 13 fractional bits) once per element and streams out the normalized probabilities over a valid/ready handshake. It sits between the exp unit and the score×V multiplier and owns the only divider instance in the softmax path.

---
 rtl/softmax_div_ctrl.sv | 133 +++++++++++++
 tb/tb_softmax_div_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/softmax_div_ctrl.sv
// Softmax row normalizer: buffers one row of exp scores while summing, then
// divides each element by the saturated row sum through an external divider.
module softmax_div_ctrl #(
  parameter int D_W     = 16,
  parameter int ROW_LEN = 8,
  parameter int IDX_W   = $clog2(ROW_LEN)
) (
  input  logic           I_CLK,
  input  logic           I_RST_N,
  input  logic           I_VALID,
  output logic           O_READY,
  input  logic [D_W-1:0] I_DATA,
  output logic [D_W-1:0] O_DIV_DIVIDEND,
  output logic [D_W-1:0] O_DIV_DIVISOR,
  input  logic [D_W-1:0] I_DIV_QUOTIENT,
  output logic           O_VALID,
  input  logic           I_READY,
  output logic [D_W-1:0] O_DATA,
  output logic           O_LAST,
  output logic           O_BUSY,
  output logic [1:0]     O_DBG_STATE
);

  // Handshakes: a transfer happens on the rising edge where valid && ready are
  // both high; the source holds data/last stable while valid && !ready.

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_DIV   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam int SUM_W = D_W - 1 + IDX_W;
  localparam logic [SUM_W-1:0] SAT_MAX  = {{IDX_W{1'b0}}, {(D_W-1){1'b1}}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [D_W-1:0]   buf_q [ROW_LEN];
  logic             out_valid_q, out_valid_d;
  logic [D_W-1:0]   out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             busy_q;

  logic [D_W-1:0] clamped;
  logic [D_W-1:0] divisor;
  logic           accept;
  logic           out_hs;
  logic           capture;

  assign clamped = I_DATA[D_W-1] ? '0 : I_DATA;
  assign divisor = (sum_q > SAT_MAX) ? SAT_MAX[D_W-1:0] : sum_q[D_W-1:0];

  // Ready is forced low while reset is held, even though state already reads LOAD.
  assign O_READY = I_RST_N && (state_q == S_LOAD);
  assign accept  = O_READY && I_VALID;
  assign out_hs  = out_valid_q && I_READY;
  assign capture = (state_q == S_DIV) && (!out_valid_q || I_READY);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (out_hs) out_valid_d = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          sum_d = sum_q + SUM_W'(clamped);
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d = S_DIV;
            idx_d   = '0;
          end
        end
      end
      S_DIV: begin
        if (capture) begin
          out_valid_d = 1'b1;
          out_data_d  = (divisor == '0) ? '0 : I_DIV_QUOTIENT;
          out_last_d  = (idx_q == LAST_IDX);
          idx_d       = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d = S_FLUSH;
            idx_d   = '0;
          end
        end
      end
      S_FLUSH: begin
        if (out_hs && out_last_q) begin
          state_d     = S_LOAD;
          idx_d       = '0;
          sum_d       = '0;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < ROW_LEN; i++) buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= (state_d != S_LOAD);
      if (accept) buf_q[idx_q] <= clamped;
    end
  end

  assign O_DIV_DIVIDEND = buf_q[idx_q];
  assign O_DIV_DIVISOR  = divisor;
  assign O_VALID        = out_valid_q;
  assign O_DATA         = out_data_q;
  assign O_LAST         = out_last_q;
  assign O_BUSY         = busy_q;
  assign O_DBG_STATE    = state_q;

endmodule

// File: tb/tb_softmax_div_ctrl.sv
// Directed bench for softmax_div_ctrl with ROW_LEN=4 and a behavioural Q2.13 divider.
module tb_softmax_div_ctrl;

  localparam int D_W = 16;
  localparam int RL  = 4;

  logic           I_CLK = 1'b0;
  logic           I_RST_N;
  logic           I_VALID;
  logic           O_READY;
  logic [D_W-1:0] I_DATA;
  logic [D_W-1:0] O_DIV_DIVIDEND;
  logic [D_W-1:0] O_DIV_DIVISOR;
  logic [D_W-1:0] I_DIV_QUOTIENT;
  logic           O_VALID;
  logic           I_READY;
  logic [D_W-1:0] O_DATA;
  logic           O_LAST;
  logic           O_BUSY;
  logic [1:0]     O_DBG_STATE;

  softmax_div_ctrl #(.D_W(D_W), .ROW_LEN(RL)) dut (
    .I_CLK(I_CLK), .I_RST_N(I_RST_N), .I_VALID(I_VALID), .O_READY(O_READY),
    .I_DATA(I_DATA), .O_DIV_DIVIDEND(O_DIV_DIVIDEND), .O_DIV_DIVISOR(O_DIV_DIVISOR),
    .I_DIV_QUOTIENT(I_DIV_QUOTIENT), .O_VALID(O_VALID), .I_READY(I_READY),
    .O_DATA(O_DATA), .O_LAST(O_LAST), .O_BUSY(O_BUSY), .O_DBG_STATE(O_DBG_STATE)
  );

  // clock / divider model
  always #5 I_CLK = ~I_CLK;

  // Divide-by-zero returns all ones so the block's own zero override is visible.
  function automatic logic [D_W-1:0] fx_div(input logic [D_W-1:0] n, input logic [D_W-1:0] d);
    longint a, b;
    a = longint'($signed(n));
    b = longint'($signed(d));
    if (b == 0) return '1;
    return D_W'((a * 8192) / b);
  endfunction

  assign I_DIV_QUOTIENT = fx_div(O_DIV_DIVIDEND, O_DIV_DIVISOR);

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [D_W-1:0] exp_q[$];

  typedef struct {
    string              name;
    logic [RL-1:0][15:0] din;
    logic [RL-1:0][15:0] dexp;
    int                 stall_idx;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_CLK);
    #1;
  endtask

  // driver: one input row, returns positioned one step after the last accept edge
  task automatic send_row(input logic [RL-1:0][15:0] d);
    int cnt;
    for (int i = 0; i < RL; i++) begin
      I_VALID = 1'b1;
      I_DATA  = d[i];
      cnt = 0;
      while (!O_READY && cnt < 50) begin
        tick();
        cnt++;
      end
      if (cnt >= 50) check("in_ready_timeout", 32'(cnt), 32'd0);
      tick();
    end
    I_VALID = 1'b0;
    I_DATA  = '0;
    check("div_state", 32'(O_DBG_STATE), 32'd1);
    check("div_busy", 32'(O_BUSY), 32'd1);
    check("div_ready", 32'(O_READY), 32'd0);
    check("div_valid0", 32'(O_VALID), 32'd0);
  endtask

  // collects n outputs; garbage inputs are offered the whole time to prove they are ignored
  task automatic collect(input string tag, input int n, input int stall_idx, input bit full);
    int cnt;
    I_READY = 1'b1;
    I_VALID = 1'b1;
    I_DATA  = 16'h7FFF;
    for (int k = 0; k < n; k++) begin
      cnt = 0;
      while (!O_VALID && cnt < 20) begin
        tick();
        cnt++;
      end
      check({tag, "_lat"}, 32'(cnt), (k == 0) ? 32'd1 : 32'd0);
      if (k == stall_idx) begin
        I_READY = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          check({tag, "_stall_valid"}, 32'(O_VALID), 32'd1);
          check({tag, "_stall_data"}, 32'(O_DATA), 32'(exp_q[0]));
          check({tag, "_stall_last"}, 32'(O_LAST), (k == RL-1) ? 32'd1 : 32'd0);
          check({tag, "_stall_ready"}, 32'(O_READY), 32'd0);
        end
        I_READY = 1'b1;
      end
      check({tag, "_data"}, 32'(O_DATA), 32'(exp_q.pop_front()));
      check({tag, "_last"}, 32'(O_LAST), (k == RL-1) ? 32'd1 : 32'd0);
      check({tag, "_ready_busy"}, {30'd0, O_READY, O_BUSY}, 32'b01);
      tick();
    end
    I_VALID = 1'b0;
    I_DATA  = '0;
    if (full) begin
      check({tag, "_end_ready"}, 32'(O_READY), 32'd1);
      check({tag, "_end_valid"}, 32'(O_VALID), 32'd0);
      check({tag, "_end_busy"}, 32'(O_BUSY), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"even",    {16'h0800, 16'h0800, 16'h0800, 16'h0800}, {16'h0800, 16'h0800, 16'h0800, 16'h0800}, -1};
    vecs[1] = '{"half",    {16'h0000, 16'h0000, 16'h2000, 16'h2000}, {16'h0000, 16'h0000, 16'h1000, 16'h1000}, -1};
    vecs[2] = '{"sat",     {16'h7000, 16'h7000, 16'h7000, 16'h7000}, {16'h1C00, 16'h1C00, 16'h1C00, 16'h1C00}, -1};
    vecs[3] = '{"zero",    {16'h0000, 16'h0000, 16'h0000, 16'h0000}, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, -1};
    vecs[4] = '{"neg",     {16'hF000, 16'hF000, 16'hF000, 16'hF000}, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, -1};
    vecs[5] = '{"mixneg",  {16'h0000, 16'h2000, 16'hF000, 16'h2000}, {16'h0000, 16'h1000, 16'h0000, 16'h1000}, -1};
    vecs[6] = '{"bp",      {16'h0000, 16'h0800, 16'h0800, 16'h1000}, {16'h0000, 16'h0800, 16'h0800, 16'h1000}, 2};

    // reset
    I_RST_N = 1'b0;
    I_VALID = 1'b0;
    I_DATA  = '0;
    I_READY = 1'b1;
    repeat (3) tick();
    check("rst_ready", 32'(O_READY), 32'd0);
    check("rst_valid", 32'(O_VALID), 32'd0);
    check("rst_data", 32'(O_DATA), 32'd0);
    check("rst_last", 32'(O_LAST), 32'd0);
    check("rst_busy", 32'(O_BUSY), 32'd0);
    I_RST_N = 1'b1;
    #1;
    check("post_rst_ready", 32'(O_READY), 32'd1);

    // table-driven rows (packed arrays hold element 0 in the low 16 bits)
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < RL; i++) exp_q.push_back(vecs[v].dexp[i]);
      send_row(vecs[v].din);
      collect(vecs[v].name, RL, vecs[v].stall_idx, 1'b1);
    end

    // reset in DIV after two outputs, then a clean row
    for (int i = 0; i < RL; i++) exp_q.push_back(vecs[1].dexp[i]);
    send_row(vecs[1].din);
    collect("prerst", 2, -1, 1'b0);
    I_RST_N = 1'b0;
    tick();
    I_RST_N = 1'b1;
    #1;
    check("midrst_valid", 32'(O_VALID), 32'd0);
    check("midrst_ready", 32'(O_READY), 32'd1);
    check("midrst_busy", 32'(O_BUSY), 32'd0);
    check("midrst_last", 32'(O_LAST), 32'd0);
    exp_q.delete();
    for (int i = 0; i < RL; i++) exp_q.push_back(vecs[0].dexp[i]);
    send_row(vecs[0].din);
    collect("postrst", RL, -1, 1'b1);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
